// File: rtl/piso_sreg_pkg.sv
// Shared definitions for the serial-register family: shifter FSM states
// and the helper that sizes bit counters for a given word width.
package piso_sreg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of a counter that must hold 0..w-1; never narrower than one bit.
  function automatic int bitCntWidth(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// Modulo-WIDTH bit counter. It advances once per shifted bit and flags
// the cycle in which the final bit of a word is on the serial output.
module piso_bitcnt
  import piso_sreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  localparam int CW = bitCntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  assign o_last = (r_count == LAST_IDX);

  // Clear wins over increment so a newly accepted word always starts at bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_sreg.sv
// Parallel-in serial-out shift register with a valid/ready load handshake.
// The sout register is loaded with the first bit on the accepting edge, so
// serial data begins the very next cycle and back-to-back words leave no gap.
module piso_sreg
  import piso_sreg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pinp,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  state_e           r_state;
  state_e           w_nextState;
  logic             w_loadReady;
  logic             w_accept;
  logic             w_last;
  logic             w_firstBit;
  logic             w_nextBit;
  logic [WIDTH-1:0] w_loadRest;
  logic [WIDTH-1:0] w_shiftRest;
  logic [WIDTH-1:0] r_shreg;
  logic             r_sout;
  logic             r_frame;

  // The shift register holds only the bits not yet presented on sout.
  assign w_firstBit  = MSB_FIRST ? pinp[WIDTH-1]    : pinp[0];
  assign w_loadRest  = MSB_FIRST ? (pinp << 1)      : (pinp >> 1);
  assign w_nextBit   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shiftRest = MSB_FIRST ? (r_shreg << 1)   : (r_shreg >> 1);

  assign w_accept = load_valid & w_loadReady;

  piso_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_accept),
    .i_inc  (r_state == SHIFT),
    .o_last (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and handshake: ready when idle or while the last bit is showing.
  always_comb begin
    w_nextState = r_state;
    w_loadReady = 1'b0;
    case (r_state)
      IDLE: begin
        w_loadReady = 1'b1;
        if (load_valid) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        w_loadReady = w_last;
        if (w_last && !load_valid) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Serial datapath: load on accept, shift mid-word, otherwise drain to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
      r_sout  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_accept;
      if (w_accept) begin
        r_sout  <= w_firstBit;
        r_shreg <= w_loadRest;
      end else if ((r_state == SHIFT) && !w_last) begin
        r_sout  <= w_nextBit;
        r_shreg <= w_shiftRest;
      end else begin
        r_sout  <= 1'b0;
        r_shreg <= '0;
      end
    end
  end

  assign load_ready  = w_loadReady;
  assign sout        = r_sout;
  assign sout_valid  = (r_state == SHIFT);
  assign busy        = (r_state == SHIFT);
  assign frame_start = r_frame;

endmodule

// File: tb/tb_piso_sreg.sv
// Bench for piso_sreg: an LSB-first and an MSB-first instance share the same
// stimulus. Expected serial streams come from a queue of pending bits per
// instance, and each stream is looped back into a SIPO register to rebuild
// the accepted words.
module tb_piso_sreg;

  logic       clk;
  logic       reset;
  logic [3:0] pinp;
  logic       load_valid;

  logic loadReadyL, soutL, soutValidL, frameStartL, busyL;
  logic loadReadyM, soutM, soutValidM, frameStartM, busyM;

  int errors;
  int checks;
  int accepted;

  bit         qL[$];
  bit         qM[$];
  logic [3:0] words[$];
  logic       expFrame;
  logic [3:0] sipoL;
  logic [3:0] sipoM;
  int         nBits;

  piso_sreg #(.WIDTH(4), .MSB_FIRST(1'b0)) dutL (
    .clk         (clk),
    .reset       (reset),
    .pinp        (pinp),
    .load_valid  (load_valid),
    .load_ready  (loadReadyL),
    .sout        (soutL),
    .sout_valid  (soutValidL),
    .frame_start (frameStartL),
    .busy        (busyL)
  );

  piso_sreg #(.WIDTH(4), .MSB_FIRST(1'b1)) dutM (
    .clk         (clk),
    .reset       (reset),
    .pinp        (pinp),
    .load_valid  (load_valid),
    .load_ready  (loadReadyM),
    .sout        (soutM),
    .sout_valid  (soutValidM),
    .frame_start (frameStartM),
    .busy        (busyM)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    qL.delete();
    qM.delete();
    words.delete();
    expFrame = 1'b0;
    sipoL = '0;
    sipoM = '0;
    nBits = 0;
  endtask

  // Compare every output against the pending-bit queues, then feed the
  // serial streams into the loopback SIPOs.
  task automatic checkOutput();
    logic expValid;
    logic [3:0] w;
    expValid = (qL.size() > 0);
    checkBit("soutL",       soutL,       expValid ? qL[0] : 1'b0);
    checkBit("soutValidL",  soutValidL,  expValid);
    checkBit("busyL",       busyL,       expValid);
    checkBit("frameStartL", frameStartL, expFrame);
    checkBit("loadReadyL",  loadReadyL,  qL.size() <= 1);
    checkBit("soutM",       soutM,       expValid ? qM[0] : 1'b0);
    checkBit("soutValidM",  soutValidM,  expValid);
    checkBit("frameStartM", frameStartM, expFrame);
    checkBit("loadReadyM",  loadReadyM,  qM.size() <= 1);
    if (expValid) begin
      sipoL = {soutL, sipoL[3:1]};
      sipoM = {sipoM[2:0], soutM};
      nBits++;
      if (nBits == 4) begin
        nBits = 0;
        if (words.size() > 0) begin
          w = words.pop_front();
          checkWord("loopbackL", sipoL, w);
          checkWord("loopbackM", sipoM, w);
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model.
  task automatic applyStimulus(input logic lv, input logic [3:0] word);
    logic acc;
    load_valid = lv;
    pinp       = word;
    @(posedge clk);
    acc = reset && lv && (qL.size() <= 1);
    if (qL.size() > 0) begin
      void'(qL.pop_front());
      void'(qM.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < 4; i++) qL.push_back(word[i]);
      for (int i = 3; i >= 0; i--) qM.push_back(word[i]);
      words.push_back(word);
      accepted++;
    end
    expFrame = acc;
    #1;
    checkOutput();
  endtask

  // Asserts reset between edges and checks the outputs clear immediately.
  task automatic assertResetNow();
    #2;
    reset = 1'b0;
    #1;
    clearModel();
    checkBit("asyncSoutL",  soutL,       1'b0);
    checkBit("asyncValidL", soutValidL,  1'b0);
    checkBit("asyncBusyL",  busyL,       1'b0);
    checkBit("asyncFrameL", frameStartL, 1'b0);
    checkBit("asyncReadyL", loadReadyL,  1'b1);
    checkBit("asyncSoutM",  soutM,       1'b0);
    checkBit("asyncValidM", soutValidM,  1'b0);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    accepted   = 0;
    reset      = 1'b0;
    load_valid = 1'b0;
    pinp       = '0;
    clearModel();

    $display("[TB] reset state, load_valid ignored during reset");
    #2;
    checkOutput();
    applyStimulus(1'b1, 4'b1011);
    applyStimulus(1'b1, 4'b1011);
    #2 reset = 1'b1;

    $display("[TB] single word 1011");
    applyStimulus(1'b1, 4'b1011);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b0000);

    $display("[TB] back-to-back 1100 then 0011");
    applyStimulus(1'b1, 4'b1100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1100);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0011);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);

    $display("[TB] load while not ready is ignored");
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 4'b1010);
    applyStimulus(1'b0, 4'b0000);
    assertResetNow();
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b0, 4'b0000);
    #2 reset = 1'b1;
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b0110);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b0000);

    $display("[TB] random words with loopback");
    accepted = 0;
    for (int c = 0; c < 300 && accepted < 16; c++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom));
    end
    checkBit("randomWordsAccepted", accepted >= 16, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_sreg.md
PISO_SREG -- requirements
Module: piso_sreg

Interface
REQ-001 Parameter WIDTH, default 4, number of bits per parallel word (minimum 2).
REQ-002 Parameter MSB_FIRST, default 0; 0 = bit 0 shifted out first, 1 = bit WIDTH-1 shifted out first.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pinp  input  WIDTH  parallel word to serialize.
REQ-006 load_valid  input  1  pinp holds a word to be accepted.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  registered serial data output.
REQ-009 sout_valid  output  1  sout carries a valid data bit this cycle.
REQ-010 frame_start  output  1  one-cycle pulse marking the first bit of each word on sout.
REQ-011 busy  output  1  a word is being shifted out.

Function
REQ-012 A word is accepted only on a rising edge where load_valid and load_ready are both 1.
REQ-013 FSM states: IDLE and SHIFT. IDLE -> SHIFT on accept. SHIFT -> IDLE after the last bit, if no new word is accepted on that edge.
REQ-014 load_ready = 1 in IDLE, and also in SHIFT during the cycle presenting the last bit; otherwise 0.
REQ-015 Latency: the first bit appears on sout in the cycle immediately after the accepting edge.
REQ-016 Each word produces exactly WIDTH consecutive cycles with sout_valid = 1, one bit per cycle, in the order set by MSB_FIRST.
REQ-017 A bit counter of width ceil(log2(WIDTH)) counts 0..WIDTH-1, then wraps to 0 on accept or returns to IDLE.
REQ-018 Back-to-back: if a word is accepted on the edge ending the last bit, its first bit follows with no idle gap; sout_valid stays 1.
REQ-019 load_valid while load_ready = 0 is ignored; pinp is sampled only on the accepting edge and may change afterwards.
REQ-020 frame_start = 1 exactly in the first-bit cycle of each word, including back-to-back words.
REQ-021 busy equals sout_valid.
REQ-022 In IDLE: sout = 0, sout_valid = 0, frame_start = 0.
REQ-023 The output order shall be such that a WIDTH-bit SIPO shift register (the team's Sreg) fed from sout reconstructs pinp after WIDTH cycles.

Reset
REQ-024 When reset = 0, the block shall clear asynchronously: state IDLE, counter 0, shift register 0, sout 0, sout_valid 0, frame_start 0, busy 0, load_ready 1 (combinational from IDLE).
REQ-025 Reset mid-word shall abandon the word with no further valid bits; after release the block is in IDLE and ready.
REQ-026 While reset = 0, load_valid shall be ignored.

Structure
REQ-027 The FSM state encoding (IDLE, SHIFT) and a bit-count-width helper constant shall reside in a shared package with the serial-register family.
REQ-028 A single sub-module, piso_bitcnt (parameterized modulo-WIDTH counter with a last-bit flag), is the natural split; the shift register and FSM shall remain in piso_sreg.

Verification (WIDTH=4 unless stated)
REQ-029 Reset release, load 4'b1011 (MSB_FIRST=0) -> next 4 cycles sout = 1,1,0,1; sout_valid = 1; frame_start only in cycle 1; then IDLE with sout = 0.
REQ-030 MSB_FIRST=1, load 4'b1011 -> sout = 1,0,1,1.
REQ-031 Back-to-back 4'b1100 then 4'b0011, with load_valid held high -> 8 contiguous valid bits 0,0,1,1,1,1,0,0; frame_start in cycles 1 and 5; load_ready high only in cycles 4 and 8.
REQ-032 Load 4'b1111, then pulse load_valid with 4'b0000 in bit 2 -> request ignored; sout stays 1 for 4 cycles.
REQ-033 Load 4'b1010, assert reset = 0 after bit 2 -> sout and sout_valid drop to 0 immediately (asynchronously); after release load_ready = 1 and a new load of 4'b0110 serializes correctly.
REQ-034 Loopback into Sreg for 16 random words -> each parallel output matches pinp once the word's 4th bit has been shifted in.
